// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch FSM plus in-order instruction queue with static JAL prediction.
module ifetch_queue #(
    parameter int          IQ_DEPTH    = 16,
    parameter int          IQ_ADDR_LEN = 4,
    parameter logic [31:0] RESET_PC    = 32'h0
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    output logic        if_read_or_not,
    output logic [31:0] intru_addr,
    input  logic        if_load_done,
    input  logic [31:0] mem_ctrl_instru_to_if,
    input  logic        flush_in,
    input  logic [31:0] flush_pc,
    output logic        iq_valid,
    output logic [31:0] iq_instr,
    output logic [31:0] iq_pc,
    output logic [31:0] iq_pred_pc,
    input  logic        iq_pop
);
    typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
    localparam logic [IQ_ADDR_LEN:0] FULL = (IQ_ADDR_LEN+1)'(IQ_DEPTH);

    state_t                 state_q, state_d;
    logic                   req_q, req_d;
    logic [31:0]            addr_q, addr_d, pc_q, pc_d;
    logic [IQ_ADDR_LEN-1:0] head_q, head_d, tail_q, tail_d;
    logic [IQ_ADDR_LEN:0]   count_q, count_d;
    logic [31:0]            instr_mem [IQ_DEPTH];
    logic [31:0]            pc_mem    [IQ_DEPTH];
    logic [31:0]            pred_mem  [IQ_DEPTH];
    logic [31:0]            word, jal_imm, pred;
    logic                   push, pop;

    assign word    = mem_ctrl_instru_to_if;
    assign jal_imm = {{11{word[31]}}, word[31], word[19:12], word[20], word[30:21], 1'b0};
    assign pred    = (word[6:0] == 7'b1101111) ? pc_q + jal_imm : pc_q + 32'd4;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        addr_d  = addr_q;
        pc_d    = pc_q;
        push    = 1'b0;
        if (flush_in) begin
            state_d = GAP;
            req_d   = 1'b0;
            pc_d    = flush_pc;
        end else begin
            case (state_q)
                IDLE: if (count_q < FULL) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = pc_q;
                end
                REQ: if (if_load_done) begin
                    push    = 1'b1;
                    pc_d    = pred;
                    req_d   = 1'b0;
                    state_d = GAP;
                end
                default: state_d = IDLE;
            endcase
        end
        pop     = iq_pop && iq_valid && !flush_in;
        head_d  = flush_in ? '0 : head_q + IQ_ADDR_LEN'(pop);
        tail_d  = flush_in ? '0 : tail_q + IQ_ADDR_LEN'(push);
        count_d = flush_in ? '0 : count_q + (IQ_ADDR_LEN+1)'(push) - (IQ_ADDR_LEN+1)'(pop);
    end

    // rdy_in low freezes every register, so outputs hold as well
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            addr_q  <= RESET_PC;
            pc_q    <= RESET_PC;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            pc_q    <= pc_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && rdy_in && push) begin
            instr_mem[tail_q] <= word;
            pc_mem[tail_q]    <= pc_q;
            pred_mem[tail_q]  <= pred;
        end
    end

    assign if_read_or_not = req_q;
    assign intru_addr     = addr_q;
    assign iq_valid       = (count_q != '0);
    assign iq_instr       = instr_mem[head_q];
    assign iq_pc          = pc_mem[head_q];
    assign iq_pred_pc     = pred_mem[head_q];
endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: directed memctrl-model stimulus with hand-computed expectations for ifetch_queue.
module tb_ifetch_queue;
    logic        clk_in = 0, rst_in = 1, rdy_in = 1;
    logic        if_read_or_not, if_load_done = 0, flush_in = 0, iq_valid, iq_pop = 0;
    logic [31:0] intru_addr, mem_ctrl_instru_to_if = 0, flush_pc = 0;
    logic [31:0] iq_instr, iq_pc, iq_pred_pc;
    int          n_checks = 0, n_errors = 0;
    logic [31:0] pc;
    logic        saw;

    ifetch_queue dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .if_read_or_not(if_read_or_not), .intru_addr(intru_addr),
        .if_load_done(if_load_done), .mem_ctrl_instru_to_if(mem_ctrl_instru_to_if),
        .flush_in(flush_in), .flush_pc(flush_pc),
        .iq_valid(iq_valid), .iq_instr(iq_instr), .iq_pc(iq_pc), .iq_pred_pc(iq_pred_pc),
        .iq_pop(iq_pop)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // wait (bounded) for a request, check its address, then answer with done held for 'hold' cycles
    task automatic serve(input logic [31:0] word, input int hold, input logic [31:0] exp_addr);
        int t = 0;
        while (!if_read_or_not && t < 20) begin
            step();
            t++;
        end
        check("req_seen", {31'b0, if_read_or_not}, 32'd1);
        check("req_addr", intru_addr, exp_addr);
        mem_ctrl_instru_to_if = word;
        if_load_done = 1;
        repeat (hold) step();
        if_load_done = 0;
    endtask

    task automatic pop_one();
        iq_pop = 1;
        step();
        iq_pop = 0;
    endtask

    task automatic watch_idle(input int n, output logic seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            step();
            seen |= if_read_or_not;
        end
    endtask

    initial begin
        repeat (3) step();
        check("rst_req", {31'b0, if_read_or_not}, 32'd0);
        check("rst_addr", intru_addr, 32'h0);
        check("rst_valid", {31'b0, iq_valid}, 32'd0);
        rst_in = 0;

        // sequential fetch of addi nops
        serve(32'h13, 1, 32'h0);
        check("t1_valid", {31'b0, iq_valid}, 32'd1);
        check("t1_pc", iq_pc, 32'h0);
        check("t1_instr", iq_instr, 32'h13);
        check("t1_pred", iq_pred_pc, 32'h4);
        serve(32'h13, 1, 32'h4);
        serve(32'h13, 1, 32'h8);
        serve(32'h13, 1, 32'hC);

        // jal x1,+8 at 0x10
        serve(32'h008000EF, 1, 32'h10);
        repeat (4) pop_one();
        check("t2_pc", iq_pc, 32'h10);
        check("t2_instr", iq_instr, 32'h008000EF);
        check("t2_pred", iq_pred_pc, 32'h18);
        serve(32'h13, 1, 32'h18);
        pop_one();
        check("t2_next_pc", iq_pc, 32'h18);
        pop_one();
        check("t2_empty", {31'b0, iq_valid}, 32'd0);

        // fill to 16 entries, then a 17th done pulse with no request
        pc = 32'h1C;
        for (int k = 0; k < 16; k++) begin
            serve(32'h13, 1, pc);
            pc += 4;
        end
        if_load_done = 1;
        step();
        if_load_done = 0;
        watch_idle(8, saw);
        check("t3_no_req_full", {31'b0, saw}, 32'd0);
        check("t3_head", iq_pc, 32'h1C);
        pop_one();
        serve(32'h13, 1, 32'h5C);
        watch_idle(8, saw);
        check("t3_one_req_only", {31'b0, saw}, 32'd0);
        for (int k = 0; k < 16; k++) begin
            check("t3_drain_valid", {31'b0, iq_valid}, 32'd1);
            check("t3_drain_pc", iq_pc, 32'h20 + 32'(4 * k));
            pop_one();
        end
        check("t3_drained", {31'b0, iq_valid}, 32'd0);

        // flush while a request at 0x60 is pending, done in flush cycle and the next
        serve(32'hDEAD0013, 0, 32'h60);
        flush_in = 1;
        flush_pc = 32'h100;
        if_load_done = 1;
        step();
        flush_in = 0;
        step();
        if_load_done = 0;
        check("t4_valid", {31'b0, iq_valid}, 32'd0);
        check("t4_req_low", {31'b0, if_read_or_not}, 32'd0);
        serve(32'h13, 1, 32'h100);
        check("t4_pc", iq_pc, 32'h100);

        // hit model: done held for two cycles pushes once
        serve(32'h13, 2, 32'h104);
        pop_one();
        check("t5_second", iq_pc, 32'h104);
        pop_one();
        check("t5_single_push", {31'b0, iq_valid}, 32'd0);

        // freeze for 5 cycles mid-request, done offered while frozen
        serve(32'h13, 0, 32'h108);
        rdy_in = 0;
        if_load_done = 1;
        for (int k = 0; k < 5; k++) begin
            step();
            check("t6_req_hold", {31'b0, if_read_or_not}, 32'd1);
            check("t6_addr_hold", intru_addr, 32'h108);
            check("t6_count_hold", {31'b0, iq_valid}, 32'd0);
        end
        if_load_done = 0;
        rdy_in = 1;
        serve(32'h13, 1, 32'h108);
        check("t6_resume_pc", iq_pc, 32'h108);
        check("t6_resume_valid", {31'b0, iq_valid}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
